// File: rtl/axis_arb_pkg.sv
// Shared types and the cyclic request picker for the frame arbiter.
// rr_pick works on a fixed 16-bit request vector, so every S_COUNT from 2 to 16 can use it.
package axis_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int RR_MAX_SRC = 16;

  // Returns the first set bit at or after ptr, wrapping at n; returns 0 when nothing is set.
  function automatic logic [3:0] rr_pick(input logic [RR_MAX_SRC-1:0] req,
                                         input logic [3:0]            ptr,
                                         input int                    n);
    logic [3:0] pick;
    logic       found;
    int         idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < RR_MAX_SRC; i++) begin
      idx = (int'(ptr) + i) % n;
      if (!found && (i < n) && req[idx]) begin
        pick  = 4'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational cyclic first-one finder; picks the lowest requester at or after ptr_i.
module rr_priority_select
  import axis_arb_pkg::*;
#(
  parameter int S_COUNT = 4
) (
  input  logic [S_COUNT-1:0]         req_i,
  input  logic [$clog2(S_COUNT)-1:0] ptr_i,
  output logic [$clog2(S_COUNT)-1:0] idx_o,
  output logic                       valid_o
);

  localparam int IDX_W = $clog2(S_COUNT);

  assign idx_o   = IDX_W'(rr_pick(RR_MAX_SRC'(req_i), 4'(ptr_i), S_COUNT));
  assign valid_o = |req_i;

endmodule

// File: rtl/axis_frame_arbiter.sv
// Frame-granular round-robin AXI-Stream merger with a per-frame length watchdog.
// Runaway frames are cut at MAX_FRAME_LEN beats, flagged bad, and the remainder is drained.
module axis_frame_arbiter
  import axis_arb_pkg::*;
#(
  parameter int S_COUNT       = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int KEEP_WIDTH    = 1,
  parameter int USER_WIDTH    = 1,
  parameter int MAX_FRAME_LEN = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [S_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [S_COUNT-1:0]            s_axis_tvalid,
  output logic [S_COUNT-1:0]            s_axis_tready,
  input  logic [S_COUNT-1:0]            s_axis_tlast,
  input  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [$clog2(S_COUNT)-1:0]    m_axis_tdest,
  output logic [USER_WIDTH-1:0]         m_axis_tuser,
  output logic                          status_truncate,
  output logic                          grant_valid,
  output logic [$clog2(S_COUNT)-1:0]    grant_index
);

  localparam int IDX_W = $clog2(S_COUNT);
  localparam int CNT_W = $clog2(MAX_FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] TRUNC_AT = CNT_W'(MAX_FRAME_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(S_COUNT - 1);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        grant_q, grant_d, rr_ptr_q, rr_ptr_d, rr_next, pick_idx;
  logic                    pick_valid;
  logic [CNT_W-1:0]        beat_cnt_q, beat_cnt_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d, sel_data;
  logic [KEEP_WIDTH-1:0]   keep_q, keep_d, sel_keep;
  logic [USER_WIDTH-1:0]   user_q, user_d, sel_user;
  logic [IDX_W-1:0]        dest_q, dest_d;
  logic                    last_q, last_d, valid_q, valid_d, trunc_q, trunc_d;
  logic                    sel_valid, sel_last, out_free, accept;

  rr_priority_select #(.S_COUNT(S_COUNT)) u_select (
    .req_i   (s_axis_tvalid),
    .ptr_i   (rr_ptr_q),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // Only the granted source's sideband is ever looked at.
  always_comb begin
    sel_data  = '0;
    sel_keep  = '0;
    sel_user  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < S_COUNT; i++) begin
      if (IDX_W'(i) == grant_q) begin
        sel_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_keep  = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
        sel_user  = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
        sel_valid = s_axis_tvalid[i];
        sel_last  = s_axis_tlast[i];
      end
    end
  end

  assign out_free = !valid_q || m_axis_tready;
  assign rr_next  = (grant_q == LAST_IDX) ? '0 : grant_q + IDX_W'(1);

  always_comb begin
    s_axis_tready = '0;
    if (state_q == PASS)
      s_axis_tready[grant_q] = out_free;
    else if (state_q == DRAIN)
      s_axis_tready[grant_q] = 1'b1;
  end

  assign accept = sel_valid && ((state_q == PASS && out_free) || state_q == DRAIN);

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    data_d     = data_q;
    keep_d     = keep_q;
    user_d     = user_q;
    last_d     = last_q;
    dest_d     = dest_q;
    valid_d    = valid_q && !m_axis_tready;
    trunc_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d    = pick_idx;
          beat_cnt_d = '0;
          state_d    = PASS;
        end
      end
      PASS: begin
        if (accept) begin
          data_d  = sel_data;
          keep_d  = sel_keep;
          user_d  = sel_user;
          last_d  = sel_last;
          dest_d  = grant_q;
          valid_d = 1'b1;
          if (sel_last) begin
            rr_ptr_d = rr_next;
            state_d  = IDLE;
          end else if (beat_cnt_q == TRUNC_AT) begin
            // Watchdog fires: close the frame early and mark it bad for the FIFO.
            last_d    = 1'b1;
            user_d[0] = 1'b1;
            trunc_d   = 1'b1;
            rr_ptr_d  = rr_next;
            state_d   = DRAIN;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
      end
      DRAIN: begin
        if (accept && sel_last)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      data_q     <= '0;
      keep_q     <= '0;
      user_q     <= '0;
      last_q     <= 1'b0;
      dest_q     <= '0;
      valid_q    <= 1'b0;
      trunc_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      data_q     <= data_d;
      keep_q     <= keep_d;
      user_q     <= user_d;
      last_q     <= last_d;
      dest_q     <= dest_d;
      valid_q    <= valid_d;
      trunc_q    <= trunc_d;
    end
  end

  assign m_axis_tdata    = data_q;
  assign m_axis_tkeep    = keep_q;
  assign m_axis_tuser    = user_q;
  assign m_axis_tlast    = last_q;
  assign m_axis_tdest    = dest_q;
  assign m_axis_tvalid   = valid_q;
  assign status_truncate = trunc_q;
  assign grant_valid     = (state_q != IDLE);
  assign grant_index     = grant_q;

endmodule
